input_port_ctrl: RTL and testbench
==================================

INPUT_PORT_CTRL -- requirements
Module: input_port_ctrl

Interface
REQ-001 Parameter DATA_W, default 33, flit width: bit DATA_W-1 is the tail flag and bits DATA_W-2:0 are the payload.
REQ-002 Parameter COORD_W, default 4, width of each destination coordinate field.
REQ-003 Parameter X_ID, default 0, X coordinate of the local router.
REQ-004 Parameter Y_ID, default 0, Y coordinate of the local router.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 fifo_empty  input  1  the upstream input FIFO is empty.
REQ-008 fifo_rd_en  output  1  read strobe to the FIFO, one pulse per flit.
REQ-009 fifo_rd_data  input  DATA_W  FIFO read data, valid in the cycle after a cycle with fifo_rd_en=1.
REQ-010 route_req  output  5  one-hot output-port request, bit order [0]=Local, [1]=N, [2]=E, [3]=S, [4]=W.
REQ-011 route_gnt  input  5  one-hot grant from the switch allocator.
REQ-012 out_valid  output  1  a flit is presented to the crossbar.
REQ-013 out_ready  input  1  the crossbar accepts the flit.
REQ-014 out_data  output  DATA_W  flit to the crossbar.
REQ-015 pkt_active  output  1  a packet is mid-transfer and holds the route.
REQ-016 pkt_cnt  output  16  count of completed packets.

Function
REQ-017 Head flit: the first flit popped after reset or after a tail flit. Head payload carries dest_x in bits 2*COORD_W-1:COORD_W and dest_y in bits COORD_W-1:0.
REQ-018 The FSM SHALL have the states IDLE, FETCH, REQ and SEND.
REQ-019 IDLE: when fifo_empty=0, drive fifo_rd_en=1 for exactly one cycle and go to FETCH. Otherwise remain in IDLE with fifo_rd_en=0.
REQ-020 FETCH: capture fifo_rd_data into the flit register.
  - Head flit: compute and latch the route, then go to REQ.
  - Other flit: go to SEND.
REQ-021 XY route, evaluated in priority order, unsigned compare:
  - dest_x>X_ID gives E.
  - dest_x<X_ID gives W.
  - Otherwise, dest_y>Y_ID gives N.
  - dest_y<Y_ID gives S.
  - Otherwise Local.
REQ-022 route_req SHALL equal the latched one-hot route from the REQ entry through the cycle of the tail-flit handshake, and be 0 otherwise.
REQ-023 REQ: go to SEND in the cycle after (route_gnt & route_req)!=0. Grants on other bits SHALL be ignored.
REQ-024 SEND: out_valid=1 and out_data=flit register only while (route_gnt & route)!=0. If the grant drops, out_valid deasserts and the block holds state.
REQ-025 A handshake occurs when out_valid=1 and out_ready=1. out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-026 On a handshake of a non-tail flit: if fifo_empty=0 in the same cycle, assert fifo_rd_en and go to FETCH; otherwise go to IDLE and keep the route.
REQ-027 On a handshake of a tail flit:
  - clear pkt_active;
  - increment pkt_cnt (wraps modulo 2^16);
  - go to IDLE;
  - drop route_req in the next cycle.
REQ-028 pkt_active SHALL be 1 from the cycle after a head flit is captured until the cycle after its tail handshake.
REQ-029 A single-flit packet (head with tail flag set) SHALL be routed and released as one packet.
REQ-030 fifo_rd_en SHALL never assert while fifo_empty=1 and never assert in FETCH or REQ.

Reset
REQ-031 While rst=1, the block SHALL be in IDLE with fifo_rd_en=0, route_req=0, out_valid=0, out_data=0, pkt_active=0 and pkt_cnt=0.
REQ-032 Reset asserted mid-packet SHALL abandon the packet. The next flit popped after reset is treated as a head flit.

Verification
REQ-033 Parameters X_ID=1, Y_ID=1. Single flit 0x1_0000_0021 (tail, dest 2,1) -> route_req=5'b00100 (E); after the grant, out_data=0x1_0000_0021 and pkt_cnt=1.
REQ-034 Four-flit packet: head dest (1,0), then two bodies, then a tail, with out_ready=1 -> route_req=5'b01000 (S) held across all four flits; four handshakes in order; route_req=0 one cycle after the tail.
REQ-035 Head dest (1,1) with route_gnt=5'b00010 (wrong bit) for 5 cycles, then 5'b00001 -> stays in REQ with out_valid=0, then delivers the flit to Local.
REQ-036 out_ready=0 for 4 cycles in SEND -> out_valid=1, out_data unchanged, and no fifo_rd_en during the stall.
REQ-037 FIFO empties mid-packet after the second flit -> the block returns to IDLE with pkt_active=1 and route_req held; later flits resume without a new route computation.
REQ-038 rst pulsed while a body flit is in SEND -> all outputs return to reset values immediately; the next popped flit is routed as a head flit.

Source files
------------

// File: rtl/input_port_ctrl_if.sv
// Bundle of the FIFO read, switch-allocator and crossbar signals seen by one router input port.
// master = the port controller, slave = the surrounding FIFO/allocator/crossbar.
interface input_port_ctrl_if #(
    parameter int DATA_W = 33
);
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] fifo_rd_data;
    logic [4:0]        route_req;
    logic [4:0]        route_gnt;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              pkt_active;
    logic [15:0]       pkt_cnt;

    modport master (
        input  fifo_empty, fifo_rd_data, route_gnt, out_ready,
        output fifo_rd_en, route_req, out_valid, out_data, pkt_active, pkt_cnt
    );

    modport slave (
        output fifo_empty, fifo_rd_data, route_gnt, out_ready,
        input  fifo_rd_en, route_req, out_valid, out_data, pkt_active, pkt_cnt
    );
endinterface

// File: rtl/input_port_ctrl.sv
// Router input-port controller: pops flits from the input FIFO, XY-routes the head flit,
// requests the switch and streams the packet to the crossbar while holding the route.
module input_port_ctrl #(
    parameter int          DATA_W  = 33,
    parameter int          COORD_W = 4,
    parameter int unsigned X_ID    = 0,
    parameter int unsigned Y_ID    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input_port_ctrl_if.master  bus
);
    localparam logic [4:0] PORT_L = 5'b00001;
    localparam logic [4:0] PORT_N = 5'b00010;
    localparam logic [4:0] PORT_E = 5'b00100;
    localparam logic [4:0] PORT_S = 5'b01000;
    localparam logic [4:0] PORT_W = 5'b10000;

    localparam logic [COORD_W-1:0] X_COORD = COORD_W'(X_ID);
    localparam logic [COORD_W-1:0] Y_COORD = COORD_W'(Y_ID);

    typedef enum logic [1:0] {IDLE, FETCH, REQ, SEND} state_t;

    state_t             state_reg, state_next;
    logic [DATA_W-1:0]  flit_reg;
    logic [4:0]         route_reg;
    logic               head_pending_reg;
    logic               pkt_active_reg;
    logic [15:0]        pkt_cnt_reg;

    logic [COORD_W-1:0] dest_x, dest_y;
    logic [4:0]         route_calc;
    logic [4:0]         gnt_match;
    logic               granted;
    logic               handshake;
    logic               is_tail;

    // Only the grant bit matching the latched route counts; stray grants are ignored.
    for (genvar gi = 0; gi < 5; gi++) begin : g_gnt_match
        assign gnt_match[gi] = bus.route_gnt[gi] & route_reg[gi];
    end

    assign granted   = |gnt_match;
    assign is_tail   = flit_reg[DATA_W-1];
    assign handshake = (state_reg == SEND) && granted && bus.out_ready;

    // Dimension-ordered route: resolve X first, then Y, else deliver locally.
    always_comb begin
        dest_x = bus.fifo_rd_data[2*COORD_W-1:COORD_W];
        dest_y = bus.fifo_rd_data[COORD_W-1:0];
        if (dest_x > X_COORD)      route_calc = PORT_E;
        else if (dest_x < X_COORD) route_calc = PORT_W;
        else if (dest_y > Y_COORD) route_calc = PORT_N;
        else if (dest_y < Y_COORD) route_calc = PORT_S;
        else                       route_calc = PORT_L;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (!bus.fifo_empty) state_next = FETCH;
            FETCH: state_next = head_pending_reg ? REQ : SEND;
            REQ:   if (granted) state_next = SEND;
            SEND: begin
                if (handshake) begin
                    if (!is_tail && !bus.fifo_empty) state_next = FETCH;
                    else                             state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.fifo_rd_en = 1'b0;
        bus.out_valid  = 1'b0;
        bus.out_data   = '0;
        if (!rst) begin
            case (state_reg)
                IDLE: bus.fifo_rd_en = !bus.fifo_empty;
                SEND: begin
                    bus.out_valid  = granted;
                    bus.out_data   = granted ? flit_reg : '0;
                    bus.fifo_rd_en = handshake && !is_tail && !bus.fifo_empty;
                end
                default: ;
            endcase
        end
        bus.route_req  = pkt_active_reg ? route_reg : 5'b00000;
        bus.pkt_active = pkt_active_reg;
        bus.pkt_cnt    = pkt_cnt_reg;
    end

    // The route survives IDLE gaps inside a packet; only a tail handshake or reset releases it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flit_reg         <= '0;
            route_reg        <= '0;
            head_pending_reg <= 1'b1;
            pkt_active_reg   <= 1'b0;
            pkt_cnt_reg      <= '0;
        end else begin
            if (state_reg == FETCH) begin
                flit_reg <= bus.fifo_rd_data;
                if (head_pending_reg) begin
                    route_reg        <= route_calc;
                    head_pending_reg <= 1'b0;
                    pkt_active_reg   <= 1'b1;
                end
            end
            if (handshake && is_tail) begin
                head_pending_reg <= 1'b1;
                pkt_active_reg   <= 1'b0;
                pkt_cnt_reg      <= pkt_cnt_reg + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_input_port_ctrl.sv
// Directed bench for input_port_ctrl at router (1,1): FIFO model, handshake log, immediate asserts.
module tb_input_port_ctrl;
    logic clk;
    logic rst;

    input_port_ctrl_if #(.DATA_W(33)) bus ();

    input_port_ctrl #(
        .DATA_W (33),
        .COORD_W(4),
        .X_ID   (1),
        .Y_ID   (1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO model: data appears the cycle after the read strobe.
    logic [32:0] fifo_mem [0:63];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_rd_data <= fifo_mem[rd_ptr[5:0]];
            rd_ptr           <= rd_ptr + 1;
        end
    end

    logic [32:0] hs_log [0:63];
    int          hs_cnt = 0;
    always @(posedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            hs_log[hs_cnt[5:0]] <= bus.out_data;
            hs_cnt              <= hs_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int base;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [32:0] f);
        fifo_mem[wr_ptr[5:0]] = f;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_hs(input int target, input string tag);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (hs_cnt >= target) break;
        end
        check(tag, 40'(hs_cnt), 40'(target));
    endtask

    initial begin
        rst = 1'b1;
        bus.route_gnt = 5'b00000;
        bus.out_ready = 1'b0;
        bus.fifo_rd_data = '0;
        #1;
        check("rst_rd_en",      40'(bus.fifo_rd_en), 40'h0);
        check("rst_route_req",  40'(bus.route_req),  40'h0);
        check("rst_out_valid",  40'(bus.out_valid),  40'h0);
        check("rst_out_data",   40'(bus.out_data),   40'h0);
        check("rst_pkt_active", 40'(bus.pkt_active), 40'h0);
        check("rst_pkt_cnt",    40'(bus.pkt_cnt),    40'h0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_empty_rd_en", 40'(bus.fifo_rd_en), 40'h0);

        // Single-flit packet to (2,1) -> East
        push(33'h1_0000_0021);
        #1;
        check("t1_rd_en", 40'(bus.fifo_rd_en), 40'h1);
        tick(); tick();
        check("t1_route_e",  40'(bus.route_req), 40'h04);
        check("t1_no_valid", 40'(bus.out_valid), 40'h0);
        check("t1_active",   40'(bus.pkt_active), 40'h1);
        base = hs_cnt;
        bus.route_gnt = 5'b00100;
        bus.out_ready = 1'b1;
        tick();
        check("t1_valid", 40'(bus.out_valid), 40'h1);
        check("t1_data",  40'(bus.out_data),  40'h1_0000_0021);
        wait_hs(base + 1, "t1_hs");
        check("t1_pkt_cnt", 40'(bus.pkt_cnt),    40'h1);
        check("t1_rel",     40'(bus.route_req),  40'h0);
        check("t1_idle",    40'(bus.pkt_active), 40'h0);

        // Four-flit packet to (1,0) -> South
        bus.route_gnt = 5'b01000;
        base = hs_cnt;
        push(33'h0_0000_0010);
        push(33'h0_0000_0AAA);
        push(33'h0_0000_0BBB);
        push(33'h1_0000_0CCC);
        tick(); tick();
        check("t2_route_s", 40'(bus.route_req), 40'h08);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hs_cnt >= base + 4) break;
            check("t2_route_hold", 40'(bus.route_req), 40'h08);
        end
        check("t2_hs_cnt",  40'(hs_cnt), 40'(base + 4));
        check("t2_release", 40'(bus.route_req), 40'h0);
        check("t2_hs0", 40'(hs_log[base]),     40'h0_0000_0010);
        check("t2_hs1", 40'(hs_log[base + 1]), 40'h0_0000_0AAA);
        check("t2_hs2", 40'(hs_log[base + 2]), 40'h0_0000_0BBB);
        check("t2_hs3", 40'(hs_log[base + 3]), 40'h1_0000_0CCC);
        check("t2_pkt_cnt", 40'(bus.pkt_cnt), 40'h2);

        // Local packet with a stray grant first
        bus.route_gnt = 5'b00010;
        base = hs_cnt;
        push(33'h1_0000_0011);
        tick(); tick();
        check("t3_route_l", 40'(bus.route_req), 40'h01);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_wrong_gnt_valid", 40'(bus.out_valid), 40'h0);
            check("t3_wrong_gnt_route", 40'(bus.route_req), 40'h01);
        end
        bus.route_gnt = 5'b00001;
        tick();
        check("t3_valid", 40'(bus.out_valid), 40'h1);
        wait_hs(base + 1, "t3_hs");
        check("t3_data",    40'(hs_log[base]), 40'h1_0000_0011);
        check("t3_pkt_cnt", 40'(bus.pkt_cnt),  40'h3);

        // Two-flit packet to (0,1) -> West, crossbar stalls 4 cycles on the head
        bus.route_gnt = 5'b10000;
        bus.out_ready = 1'b0;
        base = hs_cnt;
        push(33'h0_0000_0001);
        push(33'h1_0000_0DDD);
        tick(); tick();
        check("t4_route_w", 40'(bus.route_req), 40'h10);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_stall_valid", 40'(bus.out_valid),  40'h1);
            check("t4_stall_data",  40'(bus.out_data),   40'h0_0000_0001);
            check("t4_stall_rd_en", 40'(bus.fifo_rd_en), 40'h0);
        end
        bus.out_ready = 1'b1;
        wait_hs(base + 2, "t4_hs");
        check("t4_hs0",     40'(hs_log[base]),     40'h0_0000_0001);
        check("t4_hs1",     40'(hs_log[base + 1]), 40'h1_0000_0DDD);
        check("t4_pkt_cnt", 40'(bus.pkt_cnt), 40'h4);

        // FIFO runs dry after the body; tail arrives later, must reuse the East route
        bus.route_gnt = 5'b00100;
        base = hs_cnt;
        push(33'h0_0000_0031);
        push(33'h0_0000_0111);
        wait_hs(base + 2, "t5_hs_body");
        tick(); tick();
        check("t5_gap_active", 40'(bus.pkt_active), 40'h1);
        check("t5_gap_route",  40'(bus.route_req),  40'h04);
        check("t5_gap_valid",  40'(bus.out_valid),  40'h0);
        check("t5_gap_rd_en",  40'(bus.fifo_rd_en), 40'h0);
        push(33'h1_0000_0001);
        wait_hs(base + 3, "t5_hs_tail");
        check("t5_tail",    40'(hs_log[base + 2]), 40'h1_0000_0001);
        check("t5_pkt_cnt", 40'(bus.pkt_cnt), 40'h5);
        check("t5_release", 40'(bus.route_req), 40'h0);

        // Reset while a body flit is in SEND
        bus.route_gnt = 5'b00010;
        base = hs_cnt;
        push(33'h0_0000_0012);
        push(33'h0_0000_0333);
        wait_hs(base + 1, "t6_hs_head");
        bus.out_ready = 1'b0;
        tick();
        check("t6_body_valid", 40'(bus.out_valid), 40'h1);
        check("t6_body_data",  40'(bus.out_data),  40'h0_0000_0333);
        push(33'h1_0000_0010);
        rst = 1'b1;
        #1;
        check("t6_rst_rd_en",  40'(bus.fifo_rd_en), 40'h0);
        check("t6_rst_route",  40'(bus.route_req),  40'h0);
        check("t6_rst_valid",  40'(bus.out_valid),  40'h0);
        check("t6_rst_data",   40'(bus.out_data),   40'h0);
        check("t6_rst_active", 40'(bus.pkt_active), 40'h0);
        check("t6_rst_cnt",    40'(bus.pkt_cnt),    40'h0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("t6_new_head_route",  40'(bus.route_req),  40'h08);
        check("t6_new_head_active", 40'(bus.pkt_active), 40'h1);
        bus.route_gnt = 5'b01000;
        bus.out_ready = 1'b1;
        base = hs_cnt;
        wait_hs(base + 1, "t6_hs_new");
        check("t6_new_data", 40'(hs_log[base]), 40'h1_0000_0010);
        check("t6_pkt_cnt",  40'(bus.pkt_cnt),  40'h1);
        check("t6_release",  40'(bus.route_req), 40'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before 200000");
        $fatal(1);
    end
endmodule
